game_board_mem: RTL and testbench
=================================

# game_board_mem

Game-board storage responder for the Pac-Man core: it owns the 32x32 array of 4-bit cell codes that the game FSM reads through the read_req / gb_r_addr / data_out / valid handshake and writes through we / address / data_write. After reset it builds the initial maze itself and raises complete. It keeps a live pellet count and serves a separate display scan port for the VGA path. Cell address is {y[4:0], x[4:0]}, so address = y*32 + x.

## Interface

- No parameters: geometry is fixed at a 28x31 playfield in a 32x32 address space, with 4-bit cells.
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- we  in  1  write request; held until accepted
- address  in  10  write cell address
- data_write  in  4  write cell code
- read_req  in  1  read request; held until accepted
- gb_r_addr  in  10  read cell address
- data_out  out  4  read data; holds its last value between reads
- valid  out  1  one-cycle pulse; data_out is valid for the read just served
- busy  out  1  high means no request is accepted on the next edge
- complete  out  1  initialisation finished; board is usable
- disp_addr  in  10  display scan address
- disp_data  out  4  display cell code
- pellets_left  out  10  number of cells whose code is 4'h2

## Operation

- Cell codes: 4'h0 = empty, 4'h1 = wall, 4'h2 = pellet. Other codes are stored verbatim.
- Storage is dual-port synchronous RAM.
  - Port A is the game port. Each cycle it performs either one read or one write.
  - Port B is the display port and is read-only.
- FSM states: INIT, IDLE, WRITE, RDATA.
- INIT
  - An init counter runs 0..1023 and writes one cell per cycle:
    - x>=28 or y>=31: 4'h0.
    - Otherwise, x==0, x==27, y==0 or y==30: 4'h1.
    - Otherwise: 4'h2.
  - pellets_left increments for each 4'h2 written, ending at 754.
  - After address 1023 is written, the FSM goes to IDLE and complete goes to 1.
  - Game requests are ignored and not queued. Requesters wait for complete.
- IDLE
  - busy = 0.
  - If we = 1: latch address and data_write, issue a port-A read of the old value, go to WRITE.
  - Else if read_req = 1: issue a port-A read of gb_r_addr, go to RDATA.
  - If we and read_req are both high, the write wins. read_req stays pending and is accepted on a later IDLE edge.
- WRITE (read-modify-write)
  - Write the latched data to the RAM.
  - If old == 2 and new != 2, decrement pellets_left.
  - If old != 2 and new == 2, increment pellets_left.
  - Otherwise pellets_left is unchanged.
  - Go to IDLE.
- RDATA
  - data_out <= RAM data; valid <= 1 for exactly one cycle.
  - Go to IDLE.
- busy = 1 in INIT, WRITE and RDATA.
- A request is accepted only on an edge where busy = 0 and the request is high.
- The requester must hold the request through acceptance and deassert it on the edge after acceptance. A request still high after that is treated as a new request.
- Display port: disp_data <= RAM[disp_addr] every cycle. While complete = 0, disp_data is forced to 0.
- pellets_left saturates at 0 and at 1023; in normal operation neither limit is reachable.

## Timing

- Reset values: data_out = 0, valid = 0, busy = 1, complete = 0, disp_data = 0, pellets_left = 0. FSM state = INIT, init counter = 0.
- Reset asserted at any time, including mid-write or mid-read:
  - All outputs and state return to the reset values immediately.
  - Any pending write is dropped.
  - INIT restarts from address 0 after reset deasserts.
- Init length:
  - Cell n is written on the (n+1)-th rising edge after reset deasserts.
  - complete and busy change (to 1 and 0) on the 1025th edge.
- Read latency:
  - read_req is accepted on edge E.
  - valid and data_out update on edge E+1.
  - valid drops on edge E+2.
  - busy is high from E to E+1.
- Write latency:
  - we is accepted on edge E.
  - RAM and pellets_left update on edge E+1.
  - A read accepted on edge E+1 or later returns the new data.
- Back-to-back throughput: one request per two cycles.
- Display latency: one cycle, independent of game-port activity.

## Test plan

- Reset, then wait 1025 edges.
  - complete = 1 and pellets_left = 754.
  - Reads return: addr 0 -> 1, addr 33 -> 2, addr 28 -> 0, addr 965 -> 1, addr 1023 -> 0.
  - Each valid is a single-cycle pulse one edge after acceptance.
- Write 4'h0 to addr 33 -> pellets_left = 753 one edge after acceptance, and a read of 33 returns 0. Write 4'h2 to addr 33 -> pellets_left = 754. Write 4'h1 to addr 40 (x=8, y=1) -> pellets_left = 753.
- Assert we (addr 34, data 4'h3) and read_req (gb_r_addr 34) in the same cycle.
  - The write is accepted first; busy is high for one cycle.
  - The read is accepted at the next IDLE edge and returns data_out = 3 with valid.
  - pellets_left decrements by 1.
- Requests during INIT: read_req at cycle 10 produces no valid. A write of 4'h0 to addr 33 at cycle 10 is dropped; after complete, addr 33 reads 2 and pellets_left = 754.
- Display port: disp_addr = 0 during INIT gives disp_data = 0. After complete, disp_addr 0 -> disp_data = 1 one cycle later, and disp_addr 33 -> 2. This holds while game reads are running.
- Assert reset while in WRITE (addr 33, data 4'h0).
  - complete, busy, valid and pellets_left return to reset values immediately: busy = 1, others 0.
  - After re-init, addr 33 reads 2 and pellets_left = 754.

Source files
------------

// File: rtl/game_board_mem.sv
// -----------------------------------------------------------------------------
// game_board_mem
//
// Game-board storage for the Pac-Man core. Holds a 32x32 array of 4-bit cell
// codes (address = {y[4:0], x[4:0]}). On leaving reset it paints the initial
// maze by itself, one cell per cycle, then raises complete. It tracks the live
// number of pellet cells (code 4'h2) and serves a read-only display scan port.
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-high
//   we            write request, held by the requester until accepted
//   address       write cell address
//   data_write    write cell code
//   read_req      read request, held by the requester until accepted
//   gb_r_addr     read cell address
//   data_out      read data, holds its last value between reads
//   valid         one-cycle pulse: data_out belongs to the read just served
//   busy          high: no request will be accepted on the next edge
//   complete      board initialised and usable
//   disp_addr     display scan address
//   disp_data     display cell code, one cycle after disp_addr (0 until complete)
//   pellets_left  number of cells holding 4'h2
//   state_dbg     current FSM state (0 INIT, 1 IDLE, 2 WRITE, 3 RDATA)
//
// Handshake: a request (we or read_req) is accepted on a rising edge where it
// is high and busy is low. The requester keeps it high through that edge and
// drops it after; still high on a later edge means a new request. When both
// are high on an accepting edge the write is taken and the read stays pending.
// A read accepted on edge E has valid/data_out on E+1; a write accepted on E
// lands in the RAM and in pellets_left on E+1.
// -----------------------------------------------------------------------------
module game_board_mem (
    input  logic       clock,
    input  logic       reset,
    input  logic       we,
    input  logic [9:0] address,
    input  logic [3:0] data_write,
    input  logic       read_req,
    input  logic [9:0] gb_r_addr,
    output logic [3:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       complete,
    input  logic [9:0] disp_addr,
    output logic [3:0] disp_data,
    output logic [9:0] pellets_left,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    localparam logic [3:0] CODE_EMPTY  = 4'h0;
    localparam logic [3:0] CODE_WALL   = 4'h1;
    localparam logic [3:0] CODE_PELLET = 4'h2;
    localparam logic [9:0] PELLET_MAX  = 10'd1023;

    state_t      state;
    // Bit 10 set means all 1024 cells have been painted; the extra edge spent
    // there is what puts complete on the 1025th edge after reset.
    logic [10:0] init_cnt;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_data;

    logic [3:0]  mem [0:1023];
    logic [3:0]  a_q;
    logic [3:0]  b_q;

    logic        a_we;
    logic [9:0]  a_addr;
    logic [3:0]  a_wdata;

    logic [4:0]  init_x;
    logic [4:0]  init_y;
    logic [3:0]  init_code;

    assign state_dbg = state;

    // Initial maze: outside the 28x31 playfield is empty, its border is wall,
    // everything inside is a pellet.
    assign init_x = init_cnt[4:0];
    assign init_y = init_cnt[9:5];

    always_comb begin
        init_code = CODE_PELLET;
        if (init_x >= 5'd28 || init_y >= 5'd31) begin
            init_code = CODE_EMPTY;
        end else if (init_x == 5'd0 || init_x == 5'd27 ||
                     init_y == 5'd0 || init_y == 5'd30) begin
            init_code = CODE_WALL;
        end
    end

    // Port A: one read or one write per cycle. In IDLE the address is chosen
    // so that an accepted write fetches the old cell value for the
    // read-modify-write pellet bookkeeping in WRITE.
    always_comb begin
        a_we    = 1'b0;
        a_addr  = gb_r_addr;
        a_wdata = wr_data;
        case (state)
            S_INIT: begin
                a_we    = ~init_cnt[10];
                a_addr  = init_cnt[9:0];
                a_wdata = init_code;
            end
            S_WRITE: begin
                a_we   = 1'b1;
                a_addr = wr_addr;
            end
            S_IDLE: begin
                a_addr = we ? address : gb_r_addr;
            end
            default: begin
                a_addr = gb_r_addr;
            end
        endcase
    end

    // RAM contents are deliberately not reset; INIT repaints every cell.
    always_ff @(posedge clock) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_q <= mem[a_addr];
    end

    // Port B: display scan, read-only.
    always_ff @(posedge clock) begin
        b_q <= mem[disp_addr];
    end

    // complete is a reset register, so the display reads 0 the moment reset
    // asserts and stays 0 until the board is fully painted.
    assign disp_data = complete ? b_q : 4'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            init_cnt     <= 11'd0;
            wr_addr      <= 10'd0;
            wr_data      <= 4'h0;
            data_out     <= 4'h0;
            valid        <= 1'b0;
            busy         <= 1'b1;
            complete     <= 1'b0;
            pellets_left <= 10'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_INIT: begin
                    if (init_cnt[10]) begin
                        state    <= S_IDLE;
                        complete <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 11'd1;
                        if (init_code == CODE_PELLET && pellets_left != PELLET_MAX) begin
                            pellets_left <= pellets_left + 10'd1;
                        end
                    end
                end

                S_IDLE: begin
                    if (we) begin
                        wr_addr <= address;
                        wr_data <= data_write;
                        state   <= S_WRITE;
                        busy    <= 1'b1;
                    end else if (read_req) begin
                        state <= S_RDATA;
                        busy  <= 1'b1;
                    end
                end

                S_WRITE: begin
                    // a_q holds the old cell value fetched on the accepting edge.
                    if (a_q == CODE_PELLET && wr_data != CODE_PELLET) begin
                        if (pellets_left != 10'd0) begin
                            pellets_left <= pellets_left - 10'd1;
                        end
                    end else if (a_q != CODE_PELLET && wr_data == CODE_PELLET) begin
                        if (pellets_left != PELLET_MAX) begin
                            pellets_left <= pellets_left + 10'd1;
                        end
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                S_RDATA: begin
                    data_out <= a_q;
                    valid    <= 1'b1;
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                end

                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_board_mem.sv
// -----------------------------------------------------------------------------
// tb_game_board_mem
//
// Bench for game_board_mem: initial maze and init timing, a table of directed
// reads/writes, simultaneous write+read, requests during init, display port,
// randomized traffic against a board model, and reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_game_board_mem;

    logic       clock;
    logic       reset;
    logic       we;
    logic [9:0] address;
    logic [3:0] data_write;
    logic       read_req;
    logic [9:0] gb_r_addr;
    logic [3:0] data_out;
    logic       valid;
    logic       busy;
    logic       complete;
    logic [9:0] disp_addr;
    logic [3:0] disp_data;
    logic [9:0] pellets_left;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // Board model: what each cell should hold.
    logic [3:0] model_mem [0:1023];

    typedef struct {
        bit         is_write;
        logic [9:0] addr;
        logic [3:0] data;
        logic [3:0] exp_data;
        int         exp_pellets;
    } vec_t;

    vec_t vecs [0:9];

    game_board_mem dut (
        .clock        (clock),
        .reset        (reset),
        .we           (we),
        .address      (address),
        .data_write   (data_write),
        .read_req     (read_req),
        .gb_r_addr    (gb_r_addr),
        .data_out     (data_out),
        .valid        (valid),
        .busy         (busy),
        .complete     (complete),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .pellets_left (pellets_left),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] maze_code(input int a);
        int x;
        int y;
        x = a % 32;
        y = a / 32;
        if (x >= 28 || y >= 31) return 4'h0;
        if (x == 0 || x == 27 || y == 0 || y == 30) return 4'h1;
        return 4'h2;
    endfunction

    task automatic model_init();
        for (int a = 0; a < 1024; a++) model_mem[a] = maze_code(a);
    endtask

    function automatic int model_pellets();
        int n;
        n = 0;
        for (int a = 0; a < 1024; a++) if (model_mem[a] == 4'h2) n++;
        return n;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) tick();
        if (busy) check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_complete(input int budget);
        for (int i = 0; i < budget && !complete; i++) tick();
        check("complete_timeout", int'(complete), 1);
    endtask

    // Issue a read, check the busy/valid pulse shape, return the data.
    task automatic do_read(input logic [9:0] a, output logic [3:0] d);
        wait_idle();
        read_req  = 1'b1;
        gb_r_addr = a;
        tick();                       // accepting edge E
        read_req = 1'b0;
        check("rd_busy_after_accept", int'(busy), 1);
        check("rd_no_valid_at_accept", int'(valid), 0);
        tick();                       // E+1
        check("rd_valid_pulse", int'(valid), 1);
        d = data_out;
        tick();                       // E+2
        check("rd_valid_drop", int'(valid), 0);
    endtask

    // Issue a write; returns one edge after acceptance, when pellets_left
    // must already reflect it.
    task automatic do_write(input logic [9:0] a, input logic [3:0] d);
        wait_idle();
        we         = 1'b1;
        address    = a;
        data_write = d;
        tick();                       // accepting edge E
        we = 1'b0;
        check("wr_busy_after_accept", int'(busy), 1);
        tick();                       // E+1
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] rd;
        int         valid_seen;
        int         exp_p;

        reset      = 1'b1;
        we         = 1'b0;
        address    = 10'd0;
        data_write = 4'h0;
        read_req   = 1'b0;
        gb_r_addr  = 10'd0;
        disp_addr  = 10'd0;

        // Directed table derived from the maze rules and pellet bookkeeping.
        vecs[0] = '{1'b0, 10'd0,    4'h0, 4'h1, 754};
        vecs[1] = '{1'b0, 10'd33,   4'h0, 4'h2, 754};
        vecs[2] = '{1'b0, 10'd28,   4'h0, 4'h0, 754};
        vecs[3] = '{1'b0, 10'd965,  4'h0, 4'h1, 754};
        vecs[4] = '{1'b0, 10'd1023, 4'h0, 4'h0, 754};
        vecs[5] = '{1'b1, 10'd33,   4'h0, 4'h0, 753};
        vecs[6] = '{1'b0, 10'd33,   4'h0, 4'h0, 753};
        vecs[7] = '{1'b1, 10'd33,   4'h2, 4'h0, 754};
        vecs[8] = '{1'b1, 10'd40,   4'h1, 4'h0, 753};
        vecs[9] = '{1'b0, 10'd40,   4'h0, 4'h1, 753};

        model_init();

        // ---- reset values ----
        #2;
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_complete", int'(complete), 0);
        check("rst_disp_data", int'(disp_data), 0);
        check("rst_pellets", int'(pellets_left), 0);
        tick();
        tick();
        reset = 1'b0;

        // ---- init: exact length, requests ignored, display blanked ----
        valid_seen = 0;
        for (int e = 1; e <= 1024; e++) begin
            tick();
            if (valid) valid_seen++;
            if (e == 9) begin
                read_req   = 1'b1;
                gb_r_addr  = 10'd33;
                we         = 1'b1;
                address    = 10'd33;
                data_write = 4'h0;
            end
            if (e == 13) begin
                read_req = 1'b0;
                we       = 1'b0;
            end
            if (e == 20) check("init_disp_blank", int'(disp_data), 0);
        end
        check("init_no_valid", valid_seen, 0);
        check("init_complete_low_at_1024", int'(complete), 0);
        check("init_busy_high_at_1024", int'(busy), 1);
        tick();
        check("init_complete_at_1025", int'(complete), 1);
        check("init_busy_low_at_1025", int'(busy), 0);
        check("init_pellets", int'(pellets_left), 754);

        // ---- display port, alone and alongside a game read ----
        disp_addr = 10'd0;
        tick();
        check("disp_0", int'(disp_data), 1);
        disp_addr = 10'd33;
        tick();
        check("disp_33", int'(disp_data), 2);
        read_req  = 1'b1;
        gb_r_addr = 10'd965;
        disp_addr = 10'd28;
        tick();                       // read accepted
        read_req  = 1'b0;
        check("disp_28_during_read", int'(disp_data), 0);
        disp_addr = 10'd0;
        tick();
        check("disp_0_during_read", int'(disp_data), 1);
        check("disp_read_valid", int'(valid), 1);
        check("disp_read_data", int'(data_out), 1);
        disp_addr = 10'd33;
        tick();
        check("disp_33_after_read", int'(disp_data), 2);
        check("disp_read_valid_drop", int'(valid), 0);

        // ---- directed table ----
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_write) begin
                do_write(vecs[i].addr, vecs[i].data);
                model_mem[vecs[i].addr] = vecs[i].data;
                check($sformatf("tbl%0d_wr_pellets", i), int'(pellets_left), vecs[i].exp_pellets);
            end else begin
                do_read(vecs[i].addr, rd);
                check($sformatf("tbl%0d_rd_data", i), int'(rd), int'(vecs[i].exp_data));
                check($sformatf("tbl%0d_rd_pellets", i), int'(pellets_left), vecs[i].exp_pellets);
            end
        end

        // ---- write and read raised together: write first, read later ----
        wait_idle();
        we         = 1'b1;
        address    = 10'd34;
        data_write = 4'h3;
        read_req   = 1'b1;
        gb_r_addr  = 10'd34;
        exp_p      = int'(pellets_left) - 1;
        tick();                       // write accepted
        we = 1'b0;
        check("both_busy_write", int'(busy), 1);
        tick();
        check("both_busy_one_cycle", int'(busy), 0);
        check("both_pellets", int'(pellets_left), exp_p);
        tick();                       // pending read accepted
        read_req = 1'b0;
        check("both_busy_read", int'(busy), 1);
        tick();
        check("both_valid", int'(valid), 1);
        check("both_data", int'(data_out), 3);
        tick();
        check("both_valid_drop", int'(valid), 0);
        model_mem[34] = 4'h3;

        // ---- randomized traffic against the board model ----
        for (int i = 0; i < 80; i++) begin
            logic [9:0] a;
            logic [3:0] d;
            a = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(33, 58));
            if ($urandom_range(0, 1) == 1) begin
                d = ($urandom_range(0, 1) == 1) ? 4'h2 : 4'($urandom_range(0, 15));
                do_write(a, d);
                model_mem[a] = d;
                check("rand_wr_pellets", int'(pellets_left), model_pellets());
            end else begin
                do_read(a, rd);
                check("rand_rd_data", int'(rd), int'(model_mem[a]));
            end
        end

        // ---- reset in the middle of a write ----
        wait_idle();
        we         = 1'b1;
        address    = 10'd33;
        data_write = 4'h0;
        tick();                       // accepted, now writing
        we = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("midwr_rst_busy", int'(busy), 1);
        check("midwr_rst_complete", int'(complete), 0);
        check("midwr_rst_valid", int'(valid), 0);
        check("midwr_rst_pellets", int'(pellets_left), 0);
        check("midwr_rst_disp", int'(disp_data), 0);
        tick();
        tick();
        reset = 1'b0;
        model_init();
        wait_complete(1100);
        check("reinit_pellets", int'(pellets_left), 754);
        do_read(10'd33, rd);
        check("reinit_rd_33", int'(rd), 2);
        do_read(10'd0, rd);
        check("reinit_rd_0", int'(rd), int'(model_mem[0]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
